pee_symbolic_responder: RTL and testbench

//  Far end of the PEE symbolic-execution channel; answers each symbolic request issued by the PEE.
//  - Decodes symbolic_vars as {var_count[15:0], domain_bits[15:0]}.
//  - Enumerates packed assignments in ascending order and sends each one to an external constraint

---
 rtl/pee_pkg.sv | 42 ++++
 rtl/pee_sym_enum.sv | 40 ++++
 rtl/pee_symbolic_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_pee_symbolic_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pee_pkg.sv
// -----------------------------------------------------------------------------
// pee_pkg
//   Shared definitions for the PEE symbolic-execution responder:
//   - FSM state encoding (also exported on the responder's dbg_state port)
//   - SOL_* completion status codes reported on sol_status
//   - field slices of symbolic_vars ({var_count, domain_bits})
//   - the all-ones "no solution" assignment value
//   - space_size(): size of the packed assignment space for a bit width
// -----------------------------------------------------------------------------
package pee_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_EVAL = 3'd3,
    S_RESP      = 3'd4
  } sym_state_e;

  localparam logic [2:0] SOL_SAT     = 3'd0;
  localparam logic [2:0] SOL_UNSAT   = 3'd1;
  localparam logic [2:0] SOL_BUDGET  = 3'd2;
  localparam logic [2:0] SOL_RANGE   = 3'd3;
  localparam logic [2:0] SOL_EVAL_TO = 3'd4;

  localparam int SYMV_VARS_HI = 31;
  localparam int SYMV_VARS_LO = 16;
  localparam int SYMV_DOM_HI  = 15;
  localparam int SYMV_DOM_LO  = 0;

  localparam logic [31:0] NO_SOLUTION = 32'hFFFF_FFFF;

  // 2^nbits at 33 bits so a full 32-bit space is representable.
  // Widths above 32 return 0; callers reject those before using the result.
  function automatic logic [32:0] space_size(input logic [31:0] nbits);
    if (nbits > 32'd32) begin
      return 33'd0;
    end
    return 33'd1 << nbits[5:0];
  endfunction

endpackage

// File: rtl/pee_sym_enum.sv
// -----------------------------------------------------------------------------
// pee_sym_enum
//   Candidate enumerator: an ascending counter of packed assignments plus the
//   compare against the per-request candidate limit.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   clear       zero the candidate and capture limit (start of a search)
//   limit       number of candidates allowed for this search (33 bits)
//   advance     step to the next candidate
//   cand        current packed candidate
//   last        cand is the final candidate allowed (cand + 1 == limit)
// -----------------------------------------------------------------------------
module pee_sym_enum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [32:0] limit,
  input  logic        advance,
  output logic [31:0] cand,
  output logic        last
);

  logic [32:0] limit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand    <= 32'd0;
      limit_q <= 33'd0;
    end else if (clear) begin
      cand    <= 32'd0;
      limit_q <= limit;
    end else if (advance) begin
      cand    <= cand + 32'd1;
    end
  end

  // 33-bit compare: with a full 2^32 space the last candidate is 32'hFFFF_FFFF.
  assign last = (({1'b0, cand} + 33'd1) == limit_q);

endmodule

// File: rtl/pee_symbolic_responder.sv
// -----------------------------------------------------------------------------
// pee_symbolic_responder
//   Far end of the PEE symbolic-execution channel. For each request it decodes
//   symbolic_vars, enumerates packed assignments from 0 upwards, offers each to
//   an external constraint evaluator, and answers with the first satisfying
//   assignment (or 32'hFFFF_FFFF plus a failure status).
//
// Handshakes:
//   symbolic_req is a one-cycle pulse, honoured only in IDLE; symbolic_ack is a
//   one-cycle pulse with symbolic_assignment/sol_status already valid in that
//   cycle. Candidate channel is valid/ready: once cand_valid is high,
//   cand_value is frozen and cand_valid stays high until the cycle cand_ready
//   is sampled high (the transfer). After each transfer exactly one verdict is
//   expected on eval_valid/eval_sat within EVAL_TIMEOUT cycles; eval_valid is
//   ignored at all other times.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   symbolic_req/_vars    request pulse and {var_count, domain_bits}
//   symbolic_ack          response pulse
//   symbolic_assignment   result, held until the next response
//   cand_valid/_value     candidate to evaluator; cand_ready accepts it
//   eval_valid/eval_sat   evaluator verdict strobe and result
//   sol_status            SOL_* code of the last completed request
//   sol_busy              FSM not in IDLE
//   sol_tries             candidates transferred for current/last request
//   sol_stats             {solved_count, failed_count}, wrapping
//   req_dropped           requests seen while busy, saturating
//   dbg_state             current FSM state
// -----------------------------------------------------------------------------
module pee_symbolic_responder
  import pee_pkg::*;
#(
  parameter logic [31:0] MAX_TRIES    = 32'h4000,
  parameter int          EVAL_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        symbolic_req,
  input  logic [31:0] symbolic_vars,
  output logic        symbolic_ack,
  output logic [31:0] symbolic_assignment,
  output logic        cand_valid,
  output logic [31:0] cand_value,
  input  logic        cand_ready,
  input  logic        eval_valid,
  input  logic        eval_sat,
  output logic [2:0]  sol_status,
  output logic        sol_busy,
  output logic [31:0] sol_tries,
  output logic [31:0] sol_stats,
  output logic [15:0] req_dropped,
  output sym_state_e  dbg_state
);

  localparam logic [15:0] TO_LAST     = 16'(EVAL_TIMEOUT - 1);
  localparam logic [32:0] MAX_TRIES_W = {1'b0, MAX_TRIES};

  sym_state_e  state_q, state_d;
  logic [31:0] vars_q;
  logic [15:0] to_cnt_q;
  logic        exhaustive_q;
  logic [15:0] solved_q, failed_q;

  // Request decode, evaluated from the latched vars during SETUP.
  logic [15:0] var_count, domain_bits;
  logic [31:0] nbits;
  logic [32:0] space, limit;

  assign var_count   = vars_q[SYMV_VARS_HI:SYMV_VARS_LO];
  assign domain_bits = vars_q[SYMV_DOM_HI:SYMV_DOM_LO];
  assign nbits       = {16'd0, var_count} * {16'd0, domain_bits};
  assign space       = space_size(nbits);
  assign limit       = (space > MAX_TRIES_W) ? MAX_TRIES_W : space;

  // Enumerator
  logic        enum_clear, enum_adv;
  logic [31:0] cand;
  logic        cand_last;

  pee_sym_enum u_enum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (enum_clear),
    .limit   (limit),
    .advance (enum_adv),
    .cand    (cand),
    .last    (cand_last)
  );

  // Next-state / control
  logic        accept, handshake, finish;
  logic [31:0] result_d;
  logic [2:0]  status_d;

  always_comb begin
    state_d    = state_q;
    enum_clear = 1'b0;
    enum_adv   = 1'b0;
    accept     = 1'b0;
    handshake  = 1'b0;
    finish     = 1'b0;
    result_d   = 32'd0;
    status_d   = SOL_SAT;
    unique case (state_q)
      S_IDLE: begin
        if (symbolic_req) begin
          accept  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (var_count == 16'd0 || domain_bits == 16'd0) begin
          finish   = 1'b1;
          result_d = 32'd0;
          status_d = SOL_SAT;
          state_d  = S_RESP;
        end else if (nbits > 32'd32) begin
          finish   = 1'b1;
          result_d = NO_SOLUTION;
          status_d = SOL_RANGE;
          state_d  = S_RESP;
        end else begin
          enum_clear = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cand_ready) begin
          handshake = 1'b1;
          state_d   = S_WAIT_EVAL;
        end
      end
      S_WAIT_EVAL: begin
        // A verdict in the final timeout cycle takes priority over the timeout.
        if (eval_valid) begin
          if (eval_sat) begin
            finish   = 1'b1;
            result_d = cand;
            status_d = SOL_SAT;
            state_d  = S_RESP;
          end else if (cand_last) begin
            finish   = 1'b1;
            result_d = NO_SOLUTION;
            status_d = exhaustive_q ? SOL_UNSAT : SOL_BUDGET;
            state_d  = S_RESP;
          end else begin
            enum_adv = 1'b1;
            state_d  = S_ISSUE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          finish   = 1'b1;
          result_d = NO_SOLUTION;
          status_d = SOL_EVAL_TO;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, statistics and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vars_q              <= 32'd0;
      to_cnt_q            <= 16'd0;
      exhaustive_q        <= 1'b0;
      symbolic_assignment <= 32'd0;
      sol_status          <= SOL_SAT;
      sol_tries           <= 32'd0;
      solved_q            <= 16'd0;
      failed_q            <= 16'd0;
      req_dropped         <= 16'd0;
    end else begin
      if (accept) begin
        vars_q    <= symbolic_vars;
        sol_tries <= 32'd0;
      end
      // A budget-limited search ends in BUDGET rather than UNSAT.
      if (enum_clear) begin
        exhaustive_q <= (space <= MAX_TRIES_W);
      end
      if (handshake) begin
        sol_tries <= sol_tries + 32'd1;
        to_cnt_q  <= 16'd0;
      end else if (state_q == S_WAIT_EVAL) begin
        to_cnt_q  <= to_cnt_q + 16'd1;
      end
      // Result is written on entry to RESP so it is valid alongside the ack.
      if (finish) begin
        symbolic_assignment <= result_d;
        sol_status          <= status_d;
      end
      if (state_q == S_RESP) begin
        if (sol_status == SOL_SAT) begin
          solved_q <= solved_q + 16'd1;
        end else begin
          failed_q <= failed_q + 16'd1;
        end
      end
      if (symbolic_req && state_q != S_IDLE && req_dropped != 16'hFFFF) begin
        req_dropped <= req_dropped + 16'd1;
      end
    end
  end

  assign symbolic_ack = (state_q == S_RESP);
  assign cand_valid   = (state_q == S_ISSUE);
  assign cand_value   = cand;
  assign sol_busy     = (state_q != S_IDLE);
  assign sol_stats    = {solved_q, failed_q};
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pee_symbolic_responder.sv
// -----------------------------------------------------------------------------
// tb_pee_symbolic_responder
//   Two responders: inst 0 with the default candidate budget, inst 1 with a
//   budget of 8. One is active at a time (sel). A behavioural evaluator serves
//   the active instance; expected responses come from a spec-level model and
//   are queued, then checked by an ack monitor.
// -----------------------------------------------------------------------------
module tb_pee_symbolic_responder;
  import pee_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // per-instance signals
  logic        req        [2];
  logic [31:0] vars       [2];
  logic        ack        [2];
  logic [31:0] asg        [2];
  logic        cand_valid [2];
  logic [31:0] cand_value [2];
  logic        cand_ready [2];
  logic        eval_valid [2];
  logic        eval_sat   [2];
  logic [2:0]  status     [2];
  logic        busy       [2];
  logic [31:0] tries      [2];
  logic [31:0] stats      [2];
  logic [15:0] dropped    [2];
  sym_state_e  dbg_state  [2];

  pee_symbolic_responder u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .symbolic_req(req[0]), .symbolic_vars(vars[0]),
    .symbolic_ack(ack[0]), .symbolic_assignment(asg[0]),
    .cand_valid(cand_valid[0]), .cand_value(cand_value[0]), .cand_ready(cand_ready[0]),
    .eval_valid(eval_valid[0]), .eval_sat(eval_sat[0]),
    .sol_status(status[0]), .sol_busy(busy[0]), .sol_tries(tries[0]),
    .sol_stats(stats[0]), .req_dropped(dropped[0]), .dbg_state(dbg_state[0])
  );

  pee_symbolic_responder #(.MAX_TRIES(32'd8)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .symbolic_req(req[1]), .symbolic_vars(vars[1]),
    .symbolic_ack(ack[1]), .symbolic_assignment(asg[1]),
    .cand_valid(cand_valid[1]), .cand_value(cand_value[1]), .cand_ready(cand_ready[1]),
    .eval_valid(eval_valid[1]), .eval_sat(eval_sat[1]),
    .sol_status(status[1]), .sol_busy(busy[1]), .sol_tries(tries[1]),
    .sol_stats(stats[1]), .req_dropped(dropped[1]), .dbg_state(dbg_state[1])
  );

  // scoreboard: {inst, status[2:0], assignment[31:0], tries[31:0]}
  logic [67:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int acks_seen = 0;
  bit cv_seen = 1'b0;
  int exp_solved [2];
  int exp_failed [2];

  // evaluator configuration
  int          sel = 0;
  int          r_max = 0;
  int          r_first = 0;
  int          e_min = 0;
  int          e_max = 0;
  bit          withhold = 1'b0;
  bit          have_target = 1'b0;
  logic [31:0] target = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outcome derived from the request rules and evaluator config.
  function automatic logic [67:0] model(input int inst, input logic [31:0] v);
    longint vc, db, nb, space, lim, mt;
    logic [2:0]  st;
    logic [31:0] a, t;
    mt = (inst == 1) ? 64'd8 : 64'h4000;
    vc = longint'(v[31:16]);
    db = longint'(v[15:0]);
    nb = vc * db;
    if (vc == 0 || db == 0) begin
      a = 32'd0; st = SOL_SAT; t = 32'd0;
    end else if (nb > 32) begin
      a = 32'hFFFF_FFFF; st = SOL_RANGE; t = 32'd0;
    end else begin
      space = longint'(1) << nb;
      lim = (space < mt) ? space : mt;
      if (withhold) begin
        a = 32'hFFFF_FFFF; st = SOL_EVAL_TO; t = 32'd1;
      end else if (have_target && longint'(target) < lim) begin
        a = target; st = SOL_SAT; t = target + 32'd1;
      end else begin
        a = 32'hFFFF_FFFF;
        st = (lim == space) ? SOL_UNSAT : SOL_BUDGET;
        t = 32'(lim);
      end
    end
    return {1'(inst), st, a, t};
  endfunction

  // driver tasks
  task automatic start_req(input int inst, input logic [31:0] v, input bit push);
    logic [67:0] e;
    sel = inst;
    if (push) begin
      e = model(inst, v);
      exp_q.push_back(e);
      if (e[66:64] == SOL_SAT) exp_solved[inst]++;
      else exp_failed[inst]++;
    end
    @(negedge clk);
    vars[inst] = v;
    req[inst] = 1'b1;
    @(negedge clk);
    req[inst] = 1'b0;
  endtask

  task automatic wait_ack(input int inst, input int budget, output int lat);
    lat = 1;
    while (ack[inst] !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (ack[inst] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: inst %0d no ack within %0d cycles", inst, budget);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_req(input int inst, input logic [31:0] v, input int budget);
    int lat;
    start_req(inst, v, 1'b1);
    wait_ack(inst, budget, lat);
  endtask

  // behavioural evaluator serving the selected instance
  initial begin
    int ph, cnt, ecnt;
    logic [31:0] v;
    ph = 0; cnt = 0; ecnt = 0; v = 32'd0;
    forever begin
      @(negedge clk);
      cand_ready[0] = 1'b0; cand_ready[1] = 1'b0;
      eval_valid[0] = 1'b0; eval_valid[1] = 1'b0;
      if (!rst_n) begin
        ph = 0;
      end else begin
        case (ph)
          0: if (cand_valid[sel]) begin
               v = cand_value[sel];
               cnt = (v == 32'd0 && r_first > 0) ? r_first : int'($urandom_range(r_max, 0));
               if (cnt == 0) begin
                 cand_ready[sel] = 1'b1;
                 ecnt = int'($urandom_range(e_max, e_min));
                 ph = 2;
               end else begin
                 ph = 1;
               end
             end
          1: begin
               check("cand_valid_hold", 64'(cand_valid[sel]), 64'd1);
               check("cand_value_hold", 64'(cand_value[sel]), 64'(v));
               cnt--;
               if (cnt == 0) begin
                 cand_ready[sel] = 1'b1;
                 ecnt = int'($urandom_range(e_max, e_min));
                 ph = 2;
               end
             end
          default: begin
               if (withhold) begin
                 ph = 0;
               end else if (ecnt == 0) begin
                 eval_valid[sel] = 1'b1;
                 eval_sat[sel] = have_target && (v == target);
                 ph = 0;
               end else begin
                 ecnt--;
               end
             end
        endcase
      end
    end
  end

  // response monitor
  initial begin
    logic [67:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cand_valid[i] === 1'b1) cv_seen = 1'b1;
        if (ack[i] === 1'b1) begin
          acks_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: inst %0d assignment %0h, expected no response", i, asg[i]);
          end else begin
            e = exp_q.pop_front();
            check("resp_inst", 64'(i), 64'(e[67]));
            check("resp_status", 64'(status[i]), 64'(e[66:64]));
            check("resp_assignment", 64'(asg[i]), 64'(e[63:32]));
            check("resp_tries", 64'(tries[i]), 64'(e[31:0]));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    int lat, a0, n;
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; vars[i] = 32'd0; cand_ready[i] = 1'b0;
      eval_valid[i] = 1'b0; eval_sat[i] = 1'b0;
      exp_solved[i] = 0; exp_failed[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ack", 64'(ack[i]), 64'd0);
      check("rst_assignment", 64'(asg[i]), 64'd0);
      check("rst_cand_valid", 64'(cand_valid[i]), 64'd0);
      check("rst_status", 64'(status[i]), 64'd0);
      check("rst_busy", 64'(busy[i]), 64'd0);
      check("rst_tries", 64'(tries[i]), 64'd0);
      check("rst_stats", 64'(stats[i]), 64'd0);
      check("rst_dropped", 64'(dropped[i]), 64'd0);
      check("rst_state", 64'(dbg_state[i]), 64'(S_IDLE));
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 2 vars x 2 bits, satisfied only by 9
    have_target = 1'b1; target = 32'h9;
    run_req(0, 32'h0002_0002, 200);

    // 1 var x 2 bits, never satisfied, random handshake delays
    have_target = 1'b0; r_max = 3; e_max = 3;
    run_req(0, 32'h0001_0002, 200);

    // nbits = 35: out of range, fixed latency, no candidates
    cv_seen = 1'b0;
    start_req(0, 32'h0005_0007, 1'b1);
    wait_ack(0, 20, lat);
    check("range_latency", 64'(lat), 64'd2);
    check("range_no_cand", 64'(cv_seen), 64'd0);

    // zero-width request: trivial SAT
    cv_seen = 1'b0;
    start_req(0, 32'h0000_0005, 1'b1);
    wait_ack(0, 20, lat);
    check("trivial_latency", 64'(lat), 64'd2);
    check("trivial_no_cand", 64'(cv_seen), 64'd0);

    // budget-limited instance: 32-bit space, budget 8
    run_req(1, 32'h0004_0008, 200);
    check("stats_inst1", 64'(stats[1]), 64'({16'(exp_solved[1]), 16'(exp_failed[1])}));
    check("stats_inst0", 64'(stats[0]), 64'({16'(exp_solved[0]), 16'(exp_failed[0])}));

    // ready withheld 5 cycles, verdict withheld, extra request while busy
    r_max = 0; e_max = 0; r_first = 5; withhold = 1'b1;
    start_req(0, 32'h0002_0002, 1'b1);
    repeat (2) @(negedge clk);
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    a0 = acks_seen;
    wait_ack(0, 100, lat);
    repeat (20) @(negedge clk);
    check("no_extra_ack", 64'(acks_seen - a0), 64'd1);
    check("req_dropped", 64'(dropped[0]), 64'd1);
    r_first = 0; withhold = 1'b0;

    // verdict arriving in the last allowed cycle wins over the timeout
    e_min = 15; e_max = 15; have_target = 1'b1; target = 32'd1;
    run_req(0, 32'h0001_0001, 200);
    e_min = 0; e_max = 0;

    // reset during WAIT_EVAL abandons the search
    withhold = 1'b1;
    start_req(0, 32'h0002_0002, 1'b0);
    n = 0;
    while (dbg_state[0] != S_WAIT_EVAL && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_wait_eval", 64'(dbg_state[0] == S_WAIT_EVAL), 64'd1);
    a0 = acks_seen;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cand_valid", 64'(cand_valid[0]), 64'd0);
    check("mid_rst_state", 64'(dbg_state[0]), 64'(S_IDLE));
    check("mid_rst_busy", 64'(busy[0]), 64'd0);
    check("mid_rst_tries", 64'(tries[0]), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_solved[i] = 0; exp_failed[i] = 0;
    end
    repeat (20) @(negedge clk);
    check("mid_rst_no_ack", 64'(acks_seen - a0), 64'd0);
    withhold = 1'b0; have_target = 1'b1; target = 32'd5;
    run_req(0, 32'h0001_0003, 200);

    // randomized requests on both instances
    r_max = 2; e_min = 0; e_max = 2;
    for (int k = 0; k < 30; k++) begin
      int inst;
      inst = int'($urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0) begin
        v = {16'd2, 16'($urandom_range(40, 17))};
      end else begin
        v = {16'($urandom_range(3, 0)), 16'($urandom_range(2, 0))};
      end
      have_target = ($urandom_range(3, 0) != 0);
      target = 32'($urandom_range(80, 0));
      run_req(inst, v, 600);
    end

    // final statistics
    for (int i = 0; i < 2; i++) begin
      check("final_stats", 64'(stats[i]), 64'({16'(exp_solved[i]), 16'(exp_failed[i])}));
      check("final_dropped", 64'(dropped[i]), 64'd0);
    end
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
